// File: rtl/sect283r1_pkg.sv
// Shared sect283r1 definitions: field/curve constants, element type, checker FSM states
// and the multiply-by-z step used by the digit-serial multiplier.
package sect283r1_pkg;

   localparam int M = 283;

   typedef logic [M-1:0] gf283_t;

   // Low taps of f(z) = z^283 + z^12 + z^7 + z^5 + 1
   localparam gf283_t POLY_LOW = 283'h10A1;

   localparam gf283_t CURVE_B =
      283'h27B680A_C8B8596D_A5A4AF8A_19A0303F_CA97FD76_45309FA2_A581485A_F6263E31_3B79A2F5;
   localparam gf283_t GX =
      283'h05F93925_8DB7DD90_E1934F8C_70B0DFEC_2EED25B8_557EAC9C_80E2E198_F8CDBECD_86B12053;
   localparam gf283_t GY =
      283'h03676854_FE24141C_B98FE6D4_B20D02B4_516FF702_350EDDB0_826779C8_13F0DF45_BE8112F4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL1 = 3'd1,
      S_MUL2 = 3'd2,
      S_MUL3 = 3'd3,
      S_CMP  = 3'd4,
      S_DONE = 3'd5
   } chk_state_t;

   function automatic gf283_t gf_xtime(input gf283_t v);
      return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY_LOW : '0);
   endfunction

endpackage

// File: rtl/gf283_mul.sv
// Digit-serial MSB-first GF(2^283) multiplier: p = a*b mod f in ceil(283/D) cycles.
// The start edge performs the first digit step, done pulses once p is final.
module gf283_mul
   import sect283r1_pkg::*;
#(
   parameter int MulDigit = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clr,
   input  logic   start,
   input  gf283_t a,
   input  gf283_t b,
   output logic   done,
   output gf283_t p
);

   localparam int NMUL = (M + MulDigit - 1) / MulDigit;
   localparam int PW   = NMUL * MulDigit;

   logic [PW-1:0] r_a;
   logic [PW-1:0] w_a_src;
   gf283_t        r_b;
   gf283_t        w_b_src;
   gf283_t        r_acc;
   gf283_t        w_acc;
   logic [8:0]    r_cnt;
   logic          r_busy;
   logic          r_done;

   // a is zero-extended at the top, so the padding digits are consumed first and are harmless
   always_comb begin
      w_a_src = start ? PW'(a) : r_a;
      w_b_src = start ? b : r_b;
      w_acc   = start ? '0 : r_acc;
      for (int j = MulDigit - 1; j >= 0; j--) begin
         w_acc = gf_xtime(w_acc) ^ (w_a_src[PW-MulDigit+j] ? w_b_src : '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (clr) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
         end else if (start) begin
            r_a    <= w_a_src << MulDigit;
            r_b    <= b;
            r_acc  <= w_acc;
            r_cnt  <= 9'(NMUL - 1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_a   <= w_a_src << MulDigit;
            r_acc <= w_acc;
            r_cnt <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign done = r_done;
   assign p    = r_acc;

endmodule

// File: rtl/sect283r1_pt_chk.sv
// sect283r1 point-validity checker: y^2 + x*y == x^3 + x^2 + b, constant time,
// three products time-shared on one gf283_mul instance.
module sect283r1_pt_chk
   import sect283r1_pkg::*;
#(
   parameter int MulDigit = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         start,
   input  logic [282:0] x,
   input  logic [282:0] y,
   output logic         done,
   output logic         on_curve,
   output logic         is_inf
);

   chk_state_t r_state;
   gf283_t     r_x;
   gf283_t     r_y;
   gf283_t     r_s;
   gf283_t     r_t;
   gf283_t     r_u;
   logic       r_mstart;
   logic       r_done;
   logic       r_on_curve;
   logic       r_is_inf;

   logic       w_accept;
   logic       w_mstart;
   logic       w_mdone;
   gf283_t     w_ma;
   gf283_t     w_mb;
   gf283_t     w_p;

   assign w_accept = (r_state == S_IDLE) && start && !clr;
   // s = x*x starts on the accept edge straight from the ports; t and u start one cycle after entry
   assign w_mstart = w_accept || r_mstart;

   always_comb begin
      w_ma = x;
      w_mb = x;
      case (r_state)
         S_MUL2: begin
            w_ma = r_s;
            w_mb = r_x ^ 283'd1;
         end
         S_MUL3: begin
            w_ma = r_y;
            w_mb = r_x ^ r_y;
         end
         default: ;
      endcase
   end

   gf283_mul #(.MulDigit(MulDigit)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .start (w_mstart),
      .a     (w_ma),
      .b     (w_mb),
      .done  (w_mdone),
      .p     (w_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_s        <= '0;
         r_t        <= '0;
         r_u        <= '0;
         r_mstart   <= 1'b0;
         r_done     <= 1'b0;
         r_on_curve <= 1'b0;
         r_is_inf   <= 1'b0;
      end else if (clr) begin
         r_state    <= S_IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_s        <= '0;
         r_t        <= '0;
         r_u        <= '0;
         r_mstart   <= 1'b0;
         r_done     <= 1'b0;
         r_on_curve <= 1'b0;
         r_is_inf   <= 1'b0;
      end else begin
         r_mstart <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x        <= x;
                  r_y        <= y;
                  r_on_curve <= 1'b0;
                  r_is_inf   <= 1'b0;
                  r_state    <= S_MUL1;
               end
            end
            S_MUL1: begin
               if (w_mdone) begin
                  r_s      <= w_p;
                  r_mstart <= 1'b1;
                  r_state  <= S_MUL2;
               end
            end
            S_MUL2: begin
               if (w_mdone) begin
                  r_t      <= w_p;
                  r_mstart <= 1'b1;
                  r_state  <= S_MUL3;
               end
            end
            S_MUL3: begin
               if (w_mdone) begin
                  r_u     <= w_p;
                  r_state <= S_CMP;
               end
            end
            S_CMP: begin
               // (0,0) encodes infinity and is accepted regardless of the curve equation
               r_is_inf   <= (r_x == '0) && (r_y == '0);
               r_on_curve <= ((r_x == '0) && (r_y == '0)) || ((r_t ^ CURVE_B) == r_u);
               r_done     <= 1'b1;
               r_state    <= S_DONE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign done     = r_done;
   assign on_curve = r_on_curve;
   assign is_inf   = r_is_inf;

endmodule

// File: tb/tb_sect283r1_pt_chk.sv
// Directed bench for sect283r1_pt_chk, run on a D=1 and a D=4 instance.
module tb_sect283r1_pt_chk;
   import sect283r1_pkg::*;

   localparam int L1 = 852;
   localparam int L4 = 216;

   logic   clk = 1'b0;
   logic   rst_n;
   logic   clr;
   logic   start1;
   logic   start4;
   gf283_t x;
   gf283_t y;
   logic   done1, on1, inf1;
   logic   done4, on4, inf4;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   sect283r1_pt_chk #(.MulDigit(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .start(start1), .x(x), .y(y),
      .done(done1), .on_curve(on1), .is_inf(inf1)
   );

   sect283r1_pt_chk #(.MulDigit(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .start(start4), .x(x), .y(y),
      .done(done4), .on_curve(on4), .is_inf(inf4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic o_done(input int sel);
      return sel != 0 ? done4 : done1;
   endfunction
   function automatic logic o_on(input int sel);
      return sel != 0 ? on4 : on1;
   endfunction
   function automatic logic o_inf(input int sel);
      return sel != 0 ? inf4 : inf1;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel != 0) start4 = v;
      else          start1 = v;
   endtask

   // One check; optionally fires an ignored second start (0,1) at cycle second_at.
   task automatic run_pt(input int sel, input string tag, input gf283_t px, input gf283_t py,
                         input logic exp_on, input logic exp_inf, input int second_at);
      int lat;
      int cyc;
      lat = (sel != 0) ? L4 : L1;
      @(negedge clk);
      x = px;
      y = py;
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      x = ~px;
      y = ~py;
      for (cyc = 1; cyc <= lat + 20; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc == second_at + 1) set_start(sel, 1'b0);
         if (cyc == 1) begin
            check({tag, ".clr_on"}, 32'(o_on(sel)), 32'd0);
            check({tag, ".clr_inf"}, 32'(o_inf(sel)), 32'd0);
         end
         if (o_done(sel)) break;
         if (cyc == second_at) begin
            x = '0;
            y = 283'd1;
            set_start(sel, 1'b1);
         end
      end
      set_start(sel, 1'b0);
      check({tag, ".latency"}, 32'(cyc), 32'(lat));
      check({tag, ".on_curve"}, 32'(o_on(sel)), 32'(exp_on));
      check({tag, ".is_inf"}, 32'(o_inf(sel)), 32'(exp_inf));
      repeat (3) @(posedge clk);
      #1;
      check({tag, ".done_pulse"}, 32'(o_done(sel)), 32'd0);
      check({tag, ".hold_on"}, 32'(o_on(sel)), 32'(exp_on));
   endtask

   // Start G, abort halfway with clr or rst_n, expect no done and zeroed outputs.
   task automatic abort_run(input int sel, input string tag, input bit use_rst);
      int lat;
      int n_done;
      lat = (sel != 0) ? L4 : L1;
      n_done = 0;
      @(negedge clk);
      x = GX;
      y = GY;
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      for (int i = 0; i < lat / 2; i++) begin
         @(posedge clk);
         #1;
         if (o_done(sel)) n_done++;
      end
      @(negedge clk);
      if (use_rst) rst_n = 1'b0;
      else         clr = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      clr = 1'b0;
      for (int i = 0; i < lat + 20; i++) begin
         @(posedge clk);
         #1;
         if (o_done(sel)) n_done++;
      end
      check({tag, ".no_done"}, 32'(n_done), 32'd0);
      check({tag, ".on_zero"}, 32'(o_on(sel)), 32'd0);
      check({tag, ".inf_zero"}, 32'(o_inf(sel)), 32'd0);
   endtask

   task automatic suite(input int sel, input string p);
      gf283_t gy_f;
      gf283_t gx_f;
      gy_f = GY ^ 283'd1;
      gx_f = GX;
      gx_f[282] = ~gx_f[282];
      run_pt(sel, {p, ".g"},       GX,   GY,      1'b1, 1'b0, -1);
      run_pt(sel, {p, ".g_ybit0"}, GX,   gy_f,    1'b0, 1'b0, -1);
      run_pt(sel, {p, ".neg_g"},   GX,   GX ^ GY, 1'b1, 1'b0, -1);
      run_pt(sel, {p, ".g_xbit"},  gx_f, GY,      1'b0, 1'b0, -1);
      run_pt(sel, {p, ".inf"},     '0,   '0,      1'b1, 1'b1, -1);
      run_pt(sel, {p, ".x0y1"},    '0,   283'd1,  1'b0, 1'b0, -1);
      run_pt(sel, {p, ".g_2nd"},   GX,   GY,      1'b1, 1'b0, 100);
      abort_run(sel, {p, ".clr_abort"}, 1'b0);
      run_pt(sel, {p, ".g_after_clr"}, GX, GY, 1'b1, 1'b0, -1);
      abort_run(sel, {p, ".rst_abort"}, 1'b1);
      run_pt(sel, {p, ".g_after_rst"}, GX, GY, 1'b1, 1'b0, -1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n  = 1'b0;
      clr    = 1'b0;
      start1 = 1'b0;
      start4 = 1'b0;
      x      = '0;
      y      = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.done1", 32'(done1), 32'd0);
      check("reset.on1",   32'(on1),   32'd0);
      check("reset.inf1",  32'(inf1),  32'd0);
      check("reset.done4", 32'(done4), 32'd0);
      check("reset.on4",   32'(on4),   32'd0);
      check("reset.inf4",  32'(inf4),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      suite(0, "d1");
      suite(1, "d4");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
